// File: rtl/qtable_update_v3.sv
// Q-table update engine: neighbor lookup/append/replace by lowest Q, plus an optional
// known-cluster-head list enabled by the QTABLE_KNOWN_CH_EN macro.
module qtable_update_v3 #(
  parameter int         WORD_WIDTH = 16,
  parameter int         MAX_NBR    = 32,
  parameter int         MAX_CH     = 8,
  parameter logic [2:0] PT_CH      = 3'd1
) (
  input  logic                       clock,
  input  logic                       nrst,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [WORD_WIDTH-1:0]      f_source_id,
  input  logic [WORD_WIDTH-1:0]      f_cluster_id,
  input  logic [WORD_WIDTH-1:0]      f_energy,
  input  logic [WORD_WIDTH-1:0]      f_qvalue,
  input  logic [2:0]                 packet_type,
  input  logic [$clog2(MAX_NBR)-1:0] rd_idx,
  output logic [WORD_WIDTH-1:0]      rd_id,
  output logic [WORD_WIDTH-1:0]      rd_cluster,
  output logic [WORD_WIDTH-1:0]      rd_energy,
  output logic [WORD_WIDTH-1:0]      rd_qvalue,
  output logic [WORD_WIDTH-1:0]      neighbor_count,
  output logic [WORD_WIDTH-1:0]      ch_count,
  output logic                       done,
  output logic [1:0]                 result
);

  localparam int                    IDX_W    = $clog2(MAX_NBR);
  localparam logic [WORD_WIDTH-1:0] NBR_FULL = WORD_WIDTH'(MAX_NBR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_WRITE,
    S_CHSCAN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_UPDATED  = 2'b00,
    RES_ADDED    = 2'b01,
    RES_REPLACED = 2'b10,
    RES_DROPPED  = 2'b11
  } res_t;

  state_t                state_q;
  logic                  pkt_ready_q;
  logic                  done_q;
  res_t                  result_q;
  res_t                  res_pend_q;

  logic [WORD_WIDTH-1:0] src_q;
  logic [WORD_WIDTH-1:0] clu_q;
  logic [WORD_WIDTH-1:0] nrg_q;
  logic [WORD_WIDTH-1:0] qv_q;

  logic [WORD_WIDTH-1:0] nbr_cnt_q;
  logic [WORD_WIDTH-1:0] scan_q;
  logic [WORD_WIDTH-1:0] min_q;
  logic [IDX_W-1:0]      min_idx_q;
  logic                  match_q;
  logic [IDX_W-1:0]      match_idx_q;

  logic [WORD_WIDTH-1:0] id_mem  [MAX_NBR];
  logic [WORD_WIDTH-1:0] clu_mem [MAX_NBR];
  logic [WORD_WIDTH-1:0] nrg_mem [MAX_NBR];
  logic [WORD_WIDTH-1:0] qv_mem  [MAX_NBR];

  logic                  handshake;
  logic [IDX_W-1:0]      scan_idx;
  logic                  scan_valid;
  logic                  scan_last;
  logic                  scan_hit;
  logic                  scan_lower;

  logic                  wr_en;
  logic                  wr_all;
  logic [IDX_W-1:0]      wr_idx;
  logic                  cnt_inc;
  res_t                  wr_res;
  logic                  nbr_we;

  assign handshake  = pkt_valid && pkt_ready_q;
  assign scan_idx   = scan_q[IDX_W-1:0];
  assign scan_valid = (nbr_cnt_q != '0);
  assign scan_last  = !scan_valid || (scan_q == nbr_cnt_q - 1'b1);
  assign scan_hit   = scan_valid && (id_mem[scan_idx] == src_q);
  assign scan_lower = scan_valid && ((scan_q == '0) || (qv_mem[scan_idx] < min_q));

  // Decide the table action from what SEARCH accumulated; only acted on in WRITE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    wr_en   = 1'b0;
    wr_all  = 1'b0;
    wr_idx  = '0;
    cnt_inc = 1'b0;
    wr_res  = RES_DROPPED;
    if (match_q) begin
      wr_en  = 1'b1;
      wr_idx = match_idx_q;
      wr_res = RES_UPDATED;
    end else if (nbr_cnt_q < NBR_FULL) begin
      wr_en   = 1'b1;
      wr_all  = 1'b1;
      wr_idx  = nbr_cnt_q[IDX_W-1:0];
      cnt_inc = 1'b1;
      wr_res  = RES_ADDED;
    end else if (qv_q > min_q) begin
      wr_en  = 1'b1;
      wr_all = 1'b1;
      wr_idx = min_idx_q;
      wr_res = RES_REPLACED;
    end
  end

  assign nbr_we = (state_q == S_WRITE) && wr_en;

  // NOTE: table storage has no reset; neighbor_count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (nbr_we) begin
      if (wr_all) id_mem[wr_idx] <= src_q;
      clu_mem[wr_idx] <= clu_q;
      nrg_mem[wr_idx] <= nrg_q;
      qv_mem[wr_idx]  <= qv_q;
    end
  end

  assign rd_id      = id_mem[rd_idx];
  assign rd_cluster = clu_mem[rd_idx];
  assign rd_energy  = nrg_mem[rd_idx];
  assign rd_qvalue  = qv_mem[rd_idx];

`ifdef QTABLE_KNOWN_CH_EN
  localparam int                    CH_W    = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam logic [WORD_WIDTH-1:0] CH_FULL = WORD_WIDTH'(MAX_CH);

  logic [WORD_WIDTH-1:0] ch_mem [MAX_CH];
  logic [WORD_WIDTH-1:0] ch_cnt_q;
  logic [WORD_WIDTH-1:0] ch_scan_q;
  logic                  ch_found_q;
  logic                  is_ch_q;
  logic                  ch_last;
  logic                  ch_hit;
  logic                  ch_we;

  assign ch_last = (ch_cnt_q == '0) || (ch_scan_q == ch_cnt_q - 1'b1);
  assign ch_hit  = (ch_cnt_q != '0) && (ch_mem[ch_scan_q[CH_W-1:0]] == clu_q);
  // A full list drops new clusters silently; the neighbor result is unaffected.
  assign ch_we   = (state_q == S_CHSCAN) && ch_last && !(ch_found_q || ch_hit)
                   && (ch_cnt_q < CH_FULL);

  always_ff @(posedge clock) begin
    if (ch_we) ch_mem[ch_cnt_q[CH_W-1:0]] <= clu_q;
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      ch_cnt_q   <= '0;
      ch_scan_q  <= '0;
      ch_found_q <= 1'b0;
    end else if (state_q == S_WRITE) begin
      ch_scan_q  <= '0;
      ch_found_q <= 1'b0;
    end else if (state_q == S_CHSCAN) begin
      ch_scan_q <= ch_scan_q + 1'b1;
      if (ch_hit) ch_found_q <= 1'b1;
      if (ch_we)  ch_cnt_q   <= ch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst)          is_ch_q <= 1'b0;
    else if (handshake) is_ch_q <= (packet_type == PT_CH);
  end

  assign ch_count = ch_cnt_q;
`else
  logic unused_ch_cfg;
  assign unused_ch_cfg = ^{packet_type, PT_CH, 32'(MAX_CH)};
  assign ch_count      = '0;
`endif

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      pkt_ready_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= RES_UPDATED;
      res_pend_q  <= RES_UPDATED;
      src_q       <= '0;
      clu_q       <= '0;
      nrg_q       <= '0;
      qv_q        <= '0;
      nbr_cnt_q   <= '0;
      scan_q      <= '0;
      min_q       <= '0;
      min_idx_q   <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees last cycle's state.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pkt_ready_q <= 1'b1;
          if (handshake) begin
            src_q       <= f_source_id;
            clu_q       <= f_cluster_id;
            nrg_q       <= f_energy;
            qv_q        <= f_qvalue;
            scan_q      <= '0;
            match_q     <= 1'b0;
            pkt_ready_q <= 1'b0;
            state_q     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          scan_q <= scan_q + 1'b1;
          if (scan_hit && !match_q) begin
            match_q     <= 1'b1;
            match_idx_q <= scan_idx;
          end
          if (scan_lower) begin
            min_q     <= qv_mem[scan_idx];
            min_idx_q <= scan_idx;
          end
          if (scan_last) state_q <= S_WRITE;
        end
        S_WRITE: begin
          res_pend_q <= wr_res;
          if (cnt_inc) nbr_cnt_q <= nbr_cnt_q + 1'b1;
`ifdef QTABLE_KNOWN_CH_EN
          state_q <= is_ch_q ? S_CHSCAN : S_DONE;
`else
          state_q <= S_DONE;
`endif
        end
        S_CHSCAN: begin
`ifdef QTABLE_KNOWN_CH_EN
          if (ch_last) state_q <= S_DONE;
`else
          state_q <= S_DONE;
`endif
        end
        S_DONE: begin
          done_q      <= 1'b1;
          result_q    <= res_pend_q;
          pkt_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pkt_ready      = pkt_ready_q;
  assign done           = done_q;
  assign result         = result_q;
  assign neighbor_count = nbr_cnt_q;

endmodule
